// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - IF-stage fetch unit: imem req/gnt/rvalid sequencer plus PC-tagged instruction FIFO
module if_fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        redirect,
    output logic        pc_adv,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DISCARD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   outstanding;
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr;
    logic [31:0]     pend_pc;
    logic [31:0]     mem_instr [DEPTH];
    logic [31:0]     mem_pc    [DEPTH];
    logic            push;
    logic            pop;
    logic            credit;

    // A request is only issued when its response is guaranteed a free slot.
    assign outstanding = (state == WAIT_RESP) ? CW'(1) : '0;
    assign credit      = (count + outstanding) < DEPTH_C;

    assign push      = (state == WAIT_RESP) && imem_rvalid && !redirect;
    assign out_valid = (count != '0) && !redirect;
    assign pop       = out_valid && out_ready;

    assign imem_addr = pc_in;
    assign out_instr = mem_instr[rptr];
    assign out_pc    = mem_pc[rptr];

    // Occupancy after this cycle's push/pop, ignoring flush.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Fetch sequencer: next state, memory request and PC-advance pulse.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        pc_adv     = 1'b0;
        case (state)
            IDLE: begin
                if (credit && !redirect) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    if (!redirect) begin
                        pc_adv     = 1'b1;
                        state_next = WAIT_RESP;
                    end else begin
                        state_next = DISCARD;
                    end
                end
            end
            WAIT_RESP: begin
                if (imem_rvalid) begin
                    if (redirect || (count_next < DEPTH_C)) begin
                        state_next = REQ;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (redirect) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and PC of the request currently in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            state <= state_next;
            if (pc_adv) begin
                pend_pc <= pc_in;
            end
        end
    end

    // Fetch buffer storage and pointers; a redirect empties it and wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else begin
            assert (!(push && (count == DEPTH_C)));
            if (redirect) begin
                count <= '0;
                rptr  <= '0;
                wptr  <= '0;
            end else begin
                if (push) begin
                    mem_instr[wptr] <= imem_rdata;
                    mem_pc[wptr]    <= pend_pc;
                    wptr            <= wptr + AW'(1);
                end
                if (pop) begin
                    rptr <= rptr + AW'(1);
                end
                count <= count_next;
            end
        end
    end

endmodule
